// File: rtl/sd_crc_engine.sv
// Multi-lane serial CRC generator/checker: each lane shifts a latched word MSB-first through a
// CRC LFSR (init 0, no final XOR) and optionally compares the result with an expected CRC.
module sd_crc_engine #(
  parameter int unsigned          CRC_WIDTH  = 7,
  parameter logic [CRC_WIDTH-1:0] POLY       = 7'h09,
  parameter int unsigned          DATA_WIDTH = 40,
  parameter int unsigned          LANES      = 1
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               start_i,
  input  logic                               clear_i,
  input  logic                               mode_i,
  input  logic [LANES*DATA_WIDTH-1:0]        data_in_i,
  input  logic [LANES*CRC_WIDTH-1:0]         crc_in_i,
  output logic                               busy_o,
  output logic                               done_o,
  output logic [LANES*CRC_WIDTH-1:0]         crc_out_o,
  output logic [LANES-1:0]                   crc_ok_o,
  output logic [$clog2(DATA_WIDTH+1)-1:0]    bit_cnt_o
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                         state_q;
  logic [LANES*DATA_WIDTH-1:0]    shreg_q, shreg_d;
  logic [LANES*CRC_WIDTH-1:0]     crc_q, crc_d;
  logic [LANES*CRC_WIDTH-1:0]     crc_exp_q;
  logic                           mode_q;
  logic [CntW-1:0]                cnt_q;
  logic                           busy_q, done_q;
  logic [LANES-1:0]               crc_ok_q, crc_ok_d;
  logic                           fb;

  // One LFSR step per lane; crc_ok_d is only consumed on the final step.
  always_comb begin
    shreg_d  = shreg_q;
    crc_d    = crc_q;
    crc_ok_d = '0;
    fb       = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      fb = shreg_q[i*DATA_WIDTH + DATA_WIDTH - 1] ^ crc_q[i*CRC_WIDTH + CRC_WIDTH - 1];
      crc_d[i*CRC_WIDTH +: CRC_WIDTH] = {crc_q[i*CRC_WIDTH +: CRC_WIDTH-1], 1'b0} ^
                                        (fb ? POLY : '0);
      shreg_d[i*DATA_WIDTH +: DATA_WIDTH] = {shreg_q[i*DATA_WIDTH +: DATA_WIDTH-1], 1'b0};
      crc_ok_d[i] = mode_q & (crc_d[i*CRC_WIDTH +: CRC_WIDTH] ==
                              crc_exp_q[i*CRC_WIDTH +: CRC_WIDTH]);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      crc_q     <= '0;
      crc_exp_q <= '0;
      mode_q    <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      crc_ok_q  <= '0;
    end else if (clear_i) begin
      state_q  <= StIdle;
      shreg_q  <= '0;
      crc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      crc_ok_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            shreg_q   <= data_in_i;
            crc_q     <= '0;
            crc_exp_q <= crc_in_i;
            mode_q    <= mode_i;
            cnt_q     <= CntW'(DATA_WIDTH);
            busy_q    <= 1'b1;
            crc_ok_q  <= '0;
            state_q   <= StRun;
          end
        end
        StRun: begin
          shreg_q <= shreg_d;
          crc_q   <= crc_d;
          cnt_q   <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            crc_ok_q <= crc_ok_d;
            state_q  <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign crc_out_o = crc_q;
  assign crc_ok_o  = crc_ok_q;
  assign bit_cnt_o = cnt_q;

endmodule

// File: tb/tb_sd_crc_engine.sv
// Bench for sd_crc_engine: a 2-lane CRC7 instance and a 4-lane CRC16 instance, checked against
// a polynomial long-division reference model.
module tb_sd_crc_engine;

  logic clk, reset;

  logic          start_a, clear_a, mode_a, busy_a, done_a;
  logic [79:0]   data_a;
  logic [13:0]   crcin_a, crcout_a;
  logic [1:0]    ok_a;
  logic [5:0]    cnt_a;

  logic          start_b, clear_b, mode_b, busy_b, done_b;
  logic [16383:0] data_b;
  logic [63:0]   crcin_b, crcout_b;
  logic [3:0]    ok_b;
  logic [12:0]   cnt_b;

  int n_cmp = 0;
  int n_err = 0;

  sd_crc_engine #(.CRC_WIDTH(7), .POLY(7'h09), .DATA_WIDTH(40), .LANES(2)) u_crc7 (
    .clk_i(clk), .reset_i(reset), .start_i(start_a), .clear_i(clear_a), .mode_i(mode_a),
    .data_in_i(data_a), .crc_in_i(crcin_a), .busy_o(busy_a), .done_o(done_a),
    .crc_out_o(crcout_a), .crc_ok_o(ok_a), .bit_cnt_o(cnt_a)
  );

  sd_crc_engine #(.CRC_WIDTH(16), .POLY(16'h1021), .DATA_WIDTH(4096), .LANES(4)) u_crc16 (
    .clk_i(clk), .reset_i(reset), .start_i(start_b), .clear_i(clear_b), .mode_i(mode_b),
    .data_in_i(data_b), .crc_in_i(crcin_b), .busy_o(busy_b), .done_o(done_b),
    .crc_out_o(crcout_b), .crc_ok_o(ok_b), .bit_cnt_o(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Remainder of M(x)*x^w divided by G(x), by explicit mod-2 long division.
  function automatic logic [15:0] model_crc(input int w, input logic [15:0] poly, input int n,
                                            input logic [4095:0] msg);
    bit r[];
    bit g[];
    logic [15:0] rem;
    rem = '0;
    r = new[n + w];
    g = new[w + 1];
    for (int i = 0; i < n; i++) r[i] = msg[n-1-i];
    for (int i = n; i < n + w; i++) r[i] = 1'b0;
    g[0] = 1'b1;
    for (int j = 1; j <= w; j++) g[j] = poly[w-j];
    for (int i = 0; i < n; i++)
      if (r[i]) for (int j = 0; j <= w; j++) r[i+j] = r[i+j] ^ g[j];
    for (int j = 0; j < w; j++) rem[w-1-j] = r[n+j];
    return rem;
  endfunction

  function automatic logic [6:0] crc7_of(input logic [39:0] d);
    logic [15:0] r;
    r = model_crc(7, 16'h0009, 40, 4096'(d));
    return r[6:0];
  endfunction

  // One CRC7 operation. b2b: start is raised while the previous op is still in DONE.
  task automatic run_a(input logic [79:0] d, input logic [13:0] c, input logic m,
                       input bit b2b, input bit keep);
    logic [6:0]  e0, e1;
    logic [13:0] exp_out;
    logic [1:0]  exp_ok;
    int          k;
    e0 = crc7_of(d[39:0]);
    e1 = crc7_of(d[79:40]);
    exp_out = {e1, e0};
    exp_ok  = {m & (e1 == c[13:7]), m & (e0 == c[6:0])};
    if (!b2b) begin
      @(posedge clk); #1;
    end
    start_a = 1'b1; data_a = d; crcin_a = c; mode_a = m;
    if (b2b) begin
      @(posedge clk); #1;
      check_eq("b2b_start_ignored_in_done", {63'b0, busy_a}, 64'd0);
    end
    @(posedge clk); #1;
    start_a = 1'b0;
    data_a  = {16'($urandom), $urandom, $urandom};
    crcin_a = 14'($urandom);
    mode_a  = ~m;
    check_eq("a_busy_after_start", {63'b0, busy_a}, 64'd1);
    check_eq("a_bitcnt_after_start", 64'(cnt_a), 64'd40);
    check_eq("a_ok_cleared_on_start", 64'(ok_a), 64'd0);
    k = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (done_a) begin
        k = i;
        break;
      end
      start_a = (i < 37) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    start_a = 1'b0;
    check_eq("a_latency", 64'(k), 64'd40);
    check_eq("a_crc_out", 64'(crcout_a), 64'(exp_out));
    check_eq("a_crc_ok", 64'(ok_a), 64'(exp_ok));
    check_eq("a_bitcnt_done", 64'(cnt_a), 64'd0);
    check_eq("a_busy_done", {63'b0, busy_a}, 64'd0);
    if (keep) begin
      @(posedge clk); #1;
      check_eq("a_done_one_cycle", {63'b0, done_a}, 64'd0);
      check_eq("a_crc_out_hold", 64'(crcout_a), 64'(exp_out));
      check_eq("a_crc_ok_hold", 64'(ok_a), 64'(exp_ok));
    end
  endtask

  task automatic check_idle_zero_a(input string tag);
    check_eq({tag, "_busy"}, {63'b0, busy_a}, 64'd0);
    check_eq({tag, "_done"}, {63'b0, done_a}, 64'd0);
    check_eq({tag, "_crc_out"}, 64'(crcout_a), 64'd0);
    check_eq({tag, "_crc_ok"}, 64'(ok_a), 64'd0);
    check_eq({tag, "_bitcnt"}, 64'(cnt_a), 64'd0);
  endtask

  task automatic no_done_window_a(input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < 46; i++) begin
      @(posedge clk); #1;
      if (done_a) seen++;
    end
    check_eq(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [79:0] d;
    logic [13:0] c;
    logic [6:0]  e0, e1;
    logic [15:0] eb [4];
    logic [63:0] exp_b;
    int          k, busy_cnt;

    reset = 1'b1;
    start_a = 0; clear_a = 0; mode_a = 0; data_a = '0; crcin_a = '0;
    start_b = 0; clear_b = 0; mode_b = 0; data_b = '0; crcin_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_zero_a("reset_a");
    check_eq("reset_b_out", crcout_b, 64'd0);
    check_eq("reset_b_cnt", 64'(cnt_b), 64'd0);
    reset = 1'b0;

    // CMD0 / CMD8 tokens with known CRC7 values
    run_a({40'h48_0000_01AA, 40'h40_0000_0000}, {7'h43, 7'h4A}, 1'b1, 0, 1);
    check_eq("t2_const_out", 64'(crcout_a), 64'(14'({7'h43, 7'h4A})));
    check_eq("t2_const_ok", 64'(ok_a), 64'd3);
    run_a({40'h48_0000_01AA, 40'h40_0000_0000}, {7'h42, 7'h4A}, 1'b1, 0, 1);
    check_eq("t3_const_ok", 64'(ok_a), 64'd1);
    run_a({40'h48_0000_01AA, 40'h40_0000_0000}, {7'h43, 7'h4A}, 1'b0, 0, 1);
    check_eq("t1_const_lane0", 64'(crcout_a[6:0]), 64'h4A);

    // Clear from IDLE zeroes held result
    run_a({40'h48_0000_01AA, 40'h40_0000_0000}, {7'h43, 7'h4A}, 1'b1, 0, 1);
    clear_a = 1'b1;
    @(posedge clk); #1;
    clear_a = 1'b0;
    check_idle_zero_a("clear_idle");

    for (int t = 0; t < 16; t++) begin
      d  = {16'($urandom), $urandom, $urandom};
      e0 = crc7_of(d[39:0]);
      e1 = crc7_of(d[79:40]);
      c[6:0]  = $urandom_range(0, 1) ? e0 : 7'($urandom);
      c[13:7] = $urandom_range(0, 1) ? e1 : 7'($urandom);
      run_a(d, c, 1'($urandom_range(0, 1)), 0, (t % 4) == 0);
    end

    // Back-to-back: start held through DONE is taken the cycle after
    run_a({40'h40_0000_0000, 40'h48_0000_01AA}, {7'h4A, 7'h43}, 1'b1, 0, 0);
    run_a({40'h48_0000_01AA, 40'h40_0000_0000}, {7'h43, 7'h4A}, 1'b1, 1, 1);

    // Clear mid-run
    @(posedge clk); #1;
    start_a = 1'b1; data_a = {16'hFFFF, 64'hDEAD_BEEF_1234_5678}; mode_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    clear_a = 1'b1;
    @(posedge clk); #1;
    clear_a = 1'b0;
    check_idle_zero_a("clear_run");
    no_done_window_a("clear_run_no_done");

    // start together with clear
    start_a = 1'b1; clear_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; clear_a = 1'b0;
    check_eq("start_clear_busy", {63'b0, busy_a}, 64'd0);
    @(posedge clk); #1;
    check_eq("start_clear_busy_later", {63'b0, busy_a}, 64'd0);

    // Async reset mid-run
    start_a = 1'b1; data_a = {40'h12_3456_789A, 40'hFF_FFFF_FFFF};
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_idle_zero_a("async_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    no_done_window_a("async_reset_no_done");
    run_a({40'h48_0000_01AA, 40'h40_0000_0000}, {7'h43, 7'h4A}, 1'b0, 0, 1);
    check_eq("t6_rerun_lane0", 64'(crcout_a[6:0]), 64'h4A);

    // CRC16 over 4096 bits: lane0 all ones, other lanes random
    data_b[4095:0] = {4096{1'b1}};
    for (int w = 128; w < 512; w++) data_b[w*32 +: 32] = $urandom;
    for (int l = 0; l < 4; l++) eb[l] = model_crc(16, 16'h1021, 4096, data_b[l*4096 +: 4096]);
    crcin_b = {eb[3] ^ 16'h0001, eb[2], eb[1] ^ 16'h8000, eb[0]};
    exp_b   = {eb[3], eb[2], eb[1], eb[0]};
    @(posedge clk); #1;
    start_b = 1'b1; mode_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    check_eq("b_bitcnt_after_start", 64'(cnt_b), 64'd4096);
    busy_cnt = busy_b ? 1 : 0;
    k = 0;
    for (int i = 1; i <= 4200; i++) begin
      @(posedge clk); #1;
      if (done_b) begin
        k = i;
        break;
      end
      if (busy_b) busy_cnt++;
    end
    check_eq("b_latency", 64'(k), 64'd4096);
    check_eq("b_busy_cycles", 64'(busy_cnt), 64'd4096);
    check_eq("b_lane0_const", 64'(crcout_b[15:0]), 64'h7FA1);
    check_eq("b_crc_out", crcout_b, exp_b);
    check_eq("b_crc_ok", 64'(ok_b), 64'b0101);
    @(posedge clk); #1;
    check_eq("b_done_one_cycle", {63'b0, done_b}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
